// File: rtl/rs_alu_sim.sv
`default_nettype none
// ============================================================================
//  Module   : rs_alu_sim
//  Purpose  : ALU reservation station. Holds dispatched ops until both source
//             tags are ready, snoops the CDB for wakeups, and feeds a single
//             issue slot in lowest-index-first order with downstream stall.
//  Revision : 1.0  initial release
// ============================================================================
module rs_alu_sim #(
  parameter int RS_SIZE = 4,
  parameter int PRA_W   = 6,
  parameter int FUNC_W  = 5,
  parameter int ROB_W   = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [PRA_W-1:0]  id_pra_idx0,
  input  logic [PRA_W-1:0]  id_pra_idx1,
  input  logic              id_pra_rdy0,
  input  logic              id_pra_rdy1,
  input  logic [PRA_W-1:0]  id_dest_pra_idx,
  input  logic [FUNC_W-1:0] id_alu_func,
  input  logic [ROB_W-1:0]  id_rob_idx,
  input  logic              cdb_valid,
  input  logic [PRA_W-1:0]  cdb_pra_idx,
  input  logic              alu_sim_ready,
  output logic              rs_full,
  output logic              rs_alu_sim_valid,
  output logic [PRA_W-1:0]  rs_alu_sim_pra_idx0,
  output logic [PRA_W-1:0]  rs_alu_sim_pra_idx1,
  output logic [PRA_W-1:0]  rs_alu_sim_dest_pra_idx,
  output logic [FUNC_W-1:0] rs_alu_sim_func,
  output logic [ROB_W-1:0]  rs_alu_sim_rob_idx
);

  // Entry storage
  logic [RS_SIZE-1:0] valid_q, valid_d;
  logic [RS_SIZE-1:0] rdy0_q, rdy0_d;
  logic [RS_SIZE-1:0] rdy1_q, rdy1_d;
  logic [PRA_W-1:0]   tag0_q [RS_SIZE];
  logic [PRA_W-1:0]   tag0_d [RS_SIZE];
  logic [PRA_W-1:0]   tag1_q [RS_SIZE];
  logic [PRA_W-1:0]   tag1_d [RS_SIZE];
  logic [PRA_W-1:0]   dest_q [RS_SIZE];
  logic [PRA_W-1:0]   dest_d [RS_SIZE];
  logic [FUNC_W-1:0]  func_q [RS_SIZE];
  logic [FUNC_W-1:0]  func_d [RS_SIZE];
  logic [ROB_W-1:0]   rob_q  [RS_SIZE];
  logic [ROB_W-1:0]   rob_d  [RS_SIZE];

  // Issue slot
  logic              iss_valid_q, iss_valid_d;
  logic [PRA_W-1:0]  iss_tag0_q, iss_tag0_d;
  logic [PRA_W-1:0]  iss_tag1_q, iss_tag1_d;
  logic [PRA_W-1:0]  iss_dest_q, iss_dest_d;
  logic [FUNC_W-1:0] iss_func_q, iss_func_d;
  logic [ROB_W-1:0]  iss_rob_q, iss_rob_d;

  // Control
  logic [RS_SIZE-1:0] eligible;
  logic [RS_SIZE-1:0] disp_oh;
  logic [RS_SIZE-1:0] sel_oh;
  logic               do_dispatch;
  logic               do_issue;
  logic               disp_rdy0;
  logic               disp_rdy1;
  logic [PRA_W-1:0]   sel_tag0, sel_tag1, sel_dest;
  logic [FUNC_W-1:0]  sel_func;
  logic [ROB_W-1:0]   sel_rob;

  // Eligibility looks only at registered ready bits; a CDB hit this cycle
  // becomes visible to select one edge later.
  assign eligible    = valid_q & rdy0_q & rdy1_q;
  assign rs_full     = &valid_q;
  assign do_dispatch = id_valid & ~rs_full & ~flush;
  assign do_issue    = (~iss_valid_q | alu_sim_ready) & (|eligible) & ~flush;
  assign disp_rdy0   = id_pra_rdy0 | (cdb_valid & (cdb_pra_idx == id_pra_idx0));
  assign disp_rdy1   = id_pra_rdy1 | (cdb_valid & (cdb_pra_idx == id_pra_idx1));

  // Lowest-index free entry and lowest-index eligible entry (one-hot);
  // scanning downward leaves the lowest hit in place.
  always_comb begin
    disp_oh = '0;
    sel_oh  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        disp_oh    = '0;
        disp_oh[i] = 1'b1;
      end
      if (eligible[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  // Mux the selected entry's payload toward the issue slot.
  always_comb begin
    sel_tag0 = '0;
    sel_tag1 = '0;
    sel_dest = '0;
    sel_func = '0;
    sel_rob  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (sel_oh[i]) begin
        sel_tag0 = tag0_q[i];
        sel_tag1 = tag1_q[i];
        sel_dest = dest_q[i];
        sel_func = func_q[i];
        sel_rob  = rob_q[i];
      end
    end
  end

  // Entry next-state: wakeup, free on issue, fill on dispatch, squash on flush.
  // The dispatch target was invalid before the edge, so it never collides with
  // the entry being issued.
  always_comb begin
    valid_d = valid_q;
    rdy0_d  = rdy0_q;
    rdy1_d  = rdy1_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      tag0_d[i] = tag0_q[i];
      tag1_d[i] = tag1_q[i];
      dest_d[i] = dest_q[i];
      func_d[i] = func_q[i];
      rob_d[i]  = rob_q[i];
      if (valid_q[i] && cdb_valid && !flush) begin
        if (tag0_q[i] == cdb_pra_idx) rdy0_d[i] = 1'b1;
        if (tag1_q[i] == cdb_pra_idx) rdy1_d[i] = 1'b1;
      end
      if (do_issue && sel_oh[i]) valid_d[i] = 1'b0;
      if (do_dispatch && disp_oh[i]) begin
        valid_d[i] = 1'b1;
        rdy0_d[i]  = disp_rdy0;
        rdy1_d[i]  = disp_rdy1;
        tag0_d[i]  = id_pra_idx0;
        tag1_d[i]  = id_pra_idx1;
        dest_d[i]  = id_dest_pra_idx;
        func_d[i]  = id_alu_func;
        rob_d[i]   = id_rob_idx;
      end
      if (flush) valid_d[i] = 1'b0;
    end
  end

  // Issue slot next-state: load on free/accepted slot, drain when accepted
  // with nothing to load, otherwise hold.
  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_tag0_d  = iss_tag0_q;
    iss_tag1_d  = iss_tag1_q;
    iss_dest_d  = iss_dest_q;
    iss_func_d  = iss_func_q;
    iss_rob_d   = iss_rob_q;
    if (flush) begin
      iss_valid_d = 1'b0;
    end else if (do_issue) begin
      iss_valid_d = 1'b1;
      iss_tag0_d  = sel_tag0;
      iss_tag1_d  = sel_tag1;
      iss_dest_d  = sel_dest;
      iss_func_d  = sel_func;
      iss_rob_d   = sel_rob;
    end else if (alu_sim_ready) begin
      iss_valid_d = 1'b0;
    end
  end

  // State registers; reset clears everything so outputs read zero in reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      rdy0_q      <= '0;
      rdy1_q      <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        tag0_q[i] <= '0;
        tag1_q[i] <= '0;
        dest_q[i] <= '0;
        func_q[i] <= '0;
        rob_q[i]  <= '0;
      end
      iss_valid_q <= 1'b0;
      iss_tag0_q  <= '0;
      iss_tag1_q  <= '0;
      iss_dest_q  <= '0;
      iss_func_q  <= '0;
      iss_rob_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      rdy0_q      <= rdy0_d;
      rdy1_q      <= rdy1_d;
      for (int i = 0; i < RS_SIZE; i++) begin
        tag0_q[i] <= tag0_d[i];
        tag1_q[i] <= tag1_d[i];
        dest_q[i] <= dest_d[i];
        func_q[i] <= func_d[i];
        rob_q[i]  <= rob_d[i];
      end
      iss_valid_q <= iss_valid_d;
      iss_tag0_q  <= iss_tag0_d;
      iss_tag1_q  <= iss_tag1_d;
      iss_dest_q  <= iss_dest_d;
      iss_func_q  <= iss_func_d;
      iss_rob_q   <= iss_rob_d;
    end
  end

  assign rs_alu_sim_valid        = iss_valid_q;
  assign rs_alu_sim_pra_idx0     = iss_tag0_q;
  assign rs_alu_sim_pra_idx1     = iss_tag1_q;
  assign rs_alu_sim_dest_pra_idx = iss_dest_q;
  assign rs_alu_sim_func         = iss_func_q;
  assign rs_alu_sim_rob_idx      = iss_rob_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_alu_sim.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_alu_sim
//  Purpose  : Self-checking bench for rs_alu_sim: directed scenarios plus a
//             randomized run against a behavioural reservation-station model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rs_alu_sim;
  localparam int RS_SIZE = 4;
  localparam int PRA_W   = 6;
  localparam int FUNC_W  = 5;
  localparam int ROB_W   = 5;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              id_valid = 1'b0;
  logic [PRA_W-1:0]  id_pra_idx0 = '0;
  logic [PRA_W-1:0]  id_pra_idx1 = '0;
  logic              id_pra_rdy0 = 1'b0;
  logic              id_pra_rdy1 = 1'b0;
  logic [PRA_W-1:0]  id_dest_pra_idx = '0;
  logic [FUNC_W-1:0] id_alu_func = '0;
  logic [ROB_W-1:0]  id_rob_idx = '0;
  logic              cdb_valid = 1'b0;
  logic [PRA_W-1:0]  cdb_pra_idx = '0;
  logic              alu_sim_ready = 1'b0;
  logic              rs_full;
  logic              rs_alu_sim_valid;
  logic [PRA_W-1:0]  rs_alu_sim_pra_idx0;
  logic [PRA_W-1:0]  rs_alu_sim_pra_idx1;
  logic [PRA_W-1:0]  rs_alu_sim_dest_pra_idx;
  logic [FUNC_W-1:0] rs_alu_sim_func;
  logic [ROB_W-1:0]  rs_alu_sim_rob_idx;

  int checks = 0;
  int errors = 0;

  rs_alu_sim #(.RS_SIZE(RS_SIZE), .PRA_W(PRA_W), .FUNC_W(FUNC_W), .ROB_W(ROB_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .id_valid(id_valid),
    .id_pra_idx0(id_pra_idx0), .id_pra_idx1(id_pra_idx1),
    .id_pra_rdy0(id_pra_rdy0), .id_pra_rdy1(id_pra_rdy1),
    .id_dest_pra_idx(id_dest_pra_idx), .id_alu_func(id_alu_func), .id_rob_idx(id_rob_idx),
    .cdb_valid(cdb_valid), .cdb_pra_idx(cdb_pra_idx), .alu_sim_ready(alu_sim_ready),
    .rs_full(rs_full), .rs_alu_sim_valid(rs_alu_sim_valid),
    .rs_alu_sim_pra_idx0(rs_alu_sim_pra_idx0), .rs_alu_sim_pra_idx1(rs_alu_sim_pra_idx1),
    .rs_alu_sim_dest_pra_idx(rs_alu_sim_dest_pra_idx), .rs_alu_sim_func(rs_alu_sim_func),
    .rs_alu_sim_rob_idx(rs_alu_sim_rob_idx)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v; int t0; bit r0; int t1; bit r1; int dest; int func; int rob;
  } op_t;
  op_t m_ent [RS_SIZE];
  op_t m_slot;

  task automatic model_reset();
    for (int i = 0; i < RS_SIZE; i++) m_ent[i] = '{0, 0, 0, 0, 0, 0, 0, 0};
    m_slot = '{0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  // One clock edge of the reservation station, applied to the current inputs.
  task automatic model_edge();
    op_t nxt [RS_SIZE];
    int sel = -1;
    int free = -1;
    bit full = 1;
    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) m_ent[i].v = 0;
      m_slot.v = 0;
      return;
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!m_ent[i].v) full = 0;
      if (m_ent[i].v && m_ent[i].r0 && m_ent[i].r1 && sel < 0) sel = i;
      if (!m_ent[i].v && free < 0) free = i;
      nxt[i] = m_ent[i];
      if (m_ent[i].v && cdb_valid) begin
        if (m_ent[i].t0 == int'(cdb_pra_idx)) nxt[i].r0 = 1;
        if (m_ent[i].t1 == int'(cdb_pra_idx)) nxt[i].r1 = 1;
      end
    end
    if (!m_slot.v || alu_sim_ready) begin
      if (sel >= 0) begin
        m_slot = m_ent[sel];
        m_slot.v = 1;
        nxt[sel].v = 0;
      end else begin
        m_slot.v = 0;
      end
    end
    if (id_valid && !full) begin
      nxt[free].v    = 1;
      nxt[free].t0   = int'(id_pra_idx0);
      nxt[free].t1   = int'(id_pra_idx1);
      nxt[free].r0   = id_pra_rdy0 || (cdb_valid && cdb_pra_idx == id_pra_idx0);
      nxt[free].r1   = id_pra_rdy1 || (cdb_valid && cdb_pra_idx == id_pra_idx1);
      nxt[free].dest = int'(id_dest_pra_idx);
      nxt[free].func = int'(id_alu_func);
      nxt[free].rob  = int'(id_rob_idx);
    end
    for (int i = 0; i < RS_SIZE; i++) m_ent[i] = nxt[i];
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_valid  = 1'b0;
    flush     = 1'b0;
    cdb_valid = 1'b0;
  endtask

  task automatic drive_dispatch(input int t0, input bit r0, input int t1, input bit r1,
                                input int dest, input int func, input int rob);
    id_valid        = 1'b1;
    id_pra_idx0     = PRA_W'(t0);
    id_pra_rdy0     = r0;
    id_pra_idx1     = PRA_W'(t1);
    id_pra_rdy1     = r1;
    id_dest_pra_idx = PRA_W'(dest);
    id_alu_func     = FUNC_W'(func);
    id_rob_idx      = ROB_W'(rob);
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    step();
    checks++;
    if (rs_full !== 1'b0 || rs_alu_sim_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: full=%b valid=%b required 0 0", rs_full, rs_alu_sim_valid);
    end
    checks++;
    if ({rs_alu_sim_pra_idx0, rs_alu_sim_pra_idx1, rs_alu_sim_dest_pra_idx,
         rs_alu_sim_func, rs_alu_sim_rob_idx} !== '0) begin
      errors++;
      $display("FAIL reset_data: idx0=%0d idx1=%0d dest=%0d required all 0",
               rs_alu_sim_pra_idx0, rs_alu_sim_pra_idx1, rs_alu_sim_dest_pra_idx);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_issue();
    alu_sim_ready = 1'b1;
    drive_dispatch(3, 1, 5, 1, 9, 2, 4);
    step();
    idle();
    checks++;
    if (rs_alu_sim_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: valid=%b required 0", rs_alu_sim_valid);
    end
    step();
    checks++;
    if (rs_alu_sim_valid !== 1'b1 || rs_alu_sim_pra_idx0 !== 6'd3 || rs_alu_sim_pra_idx1 !== 6'd5 ||
        rs_alu_sim_dest_pra_idx !== 6'd9 || rs_alu_sim_func !== 5'd2 || rs_alu_sim_rob_idx !== 5'd4) begin
      errors++;
      $display("FAIL basic_issue: valid=%b idx0=%0d idx1=%0d dest=%0d func=%0d rob=%0d required 1 3 5 9 2 4",
               rs_alu_sim_valid, rs_alu_sim_pra_idx0, rs_alu_sim_pra_idx1,
               rs_alu_sim_dest_pra_idx, rs_alu_sim_func, rs_alu_sim_rob_idx);
    end
    step();
    checks++;
    if (rs_alu_sim_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: valid=%b required 0", rs_alu_sim_valid);
    end
  endtask

  task automatic test_wakeup();
    alu_sim_ready = 1'b1;
    drive_dispatch(2, 1, 7, 0, 10, 1, 1);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (rs_alu_sim_valid !== 1'b0) begin
        errors++;
        $display("FAIL wakeup_wait%0d: valid=%b required 0", k, rs_alu_sim_valid);
      end
    end
    cdb_valid = 1'b1;
    cdb_pra_idx = 6'd7;
    step();
    cdb_valid = 1'b0;
    checks++;
    if (rs_alu_sim_valid !== 1'b0) begin
      errors++;
      $display("FAIL wakeup_bypass: valid=%b required 0 at wakeup edge", rs_alu_sim_valid);
    end
    step();
    checks++;
    if (rs_alu_sim_valid !== 1'b1 || rs_alu_sim_dest_pra_idx !== 6'd10) begin
      errors++;
      $display("FAIL wakeup_issue: valid=%b dest=%0d required 1 10", rs_alu_sim_valid, rs_alu_sim_dest_pra_idx);
    end
    step();
  endtask

  task automatic test_full();
    alu_sim_ready = 1'b0;
    for (int k = 0; k < RS_SIZE; k++) begin
      checks++;
      if (rs_full !== 1'b0) begin
        errors++;
        $display("FAIL full_early%0d: full=%b required 0", k, rs_full);
      end
      drive_dispatch(20 + k, 0, 30 + k, 0, 40 + k, 0, k);
      step();
    end
    checks++;
    if (rs_full !== 1'b1) begin
      errors++;
      $display("FAIL full_set: full=%b required 1", rs_full);
    end
    drive_dispatch(1, 1, 1, 1, 50, 0, 0);
    step();
    idle();
    checks++;
    if (rs_full !== 1'b1 || rs_alu_sim_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_ignore: full=%b valid=%b required 1 0", rs_full, rs_alu_sim_valid);
    end
    cdb_valid = 1'b1;
    cdb_pra_idx = 6'd22;
    step();
    cdb_pra_idx = 6'd32;
    step();
    cdb_valid = 1'b0;
    checks++;
    if (rs_full !== 1'b1 || rs_alu_sim_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_wake: full=%b valid=%b required 1 0", rs_full, rs_alu_sim_valid);
    end
    step();
    checks++;
    if (rs_full !== 1'b0 || rs_alu_sim_valid !== 1'b1 || rs_alu_sim_dest_pra_idx !== 6'd42) begin
      errors++;
      $display("FAIL full_issue: full=%b valid=%b dest=%0d required 0 1 42",
               rs_full, rs_alu_sim_valid, rs_alu_sim_dest_pra_idx);
    end
    alu_sim_ready = 1'b1;
    step();
    checks++;
    if (rs_full !== 1'b0 || rs_alu_sim_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_accept: full=%b valid=%b required 0 0", rs_full, rs_alu_sim_valid);
    end
    do_flush();
  endtask

  task automatic test_dispatch_bypass();
    alu_sim_ready = 1'b1;
    drive_dispatch(12, 0, 13, 1, 11, 6, 3);
    cdb_valid = 1'b1;
    cdb_pra_idx = 6'd12;
    step();
    idle();
    step();
    checks++;
    if (rs_alu_sim_valid !== 1'b1 || rs_alu_sim_pra_idx0 !== 6'd12 || rs_alu_sim_dest_pra_idx !== 6'd11) begin
      errors++;
      $display("FAIL bypass_issue: valid=%b idx0=%0d dest=%0d required 1 12 11",
               rs_alu_sim_valid, rs_alu_sim_pra_idx0, rs_alu_sim_dest_pra_idx);
    end
    step();
  endtask

  task automatic test_back_to_back();
    alu_sim_ready = 1'b0;
    drive_dispatch(4, 1, 8, 1, 1, 3, 7);   // A -> entry 0
    step();
    drive_dispatch(5, 1, 9, 1, 2, 0, 0);   // B -> entry 1, A issues
    step();
    drive_dispatch(6, 1, 10, 1, 3, 0, 0);  // C -> freed entry 0
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (rs_alu_sim_valid !== 1'b1 || rs_alu_sim_pra_idx0 !== 6'd4 || rs_alu_sim_pra_idx1 !== 6'd8 ||
          rs_alu_sim_dest_pra_idx !== 6'd1 || rs_alu_sim_func !== 5'd3 || rs_alu_sim_rob_idx !== 5'd7) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b idx0=%0d idx1=%0d dest=%0d required 1 4 8 1",
                 k, rs_alu_sim_valid, rs_alu_sim_pra_idx0, rs_alu_sim_pra_idx1, rs_alu_sim_dest_pra_idx);
      end
    end
    alu_sim_ready = 1'b1;
    step();
    checks++;
    if (rs_alu_sim_valid !== 1'b1 || rs_alu_sim_dest_pra_idx !== 6'd3) begin
      errors++;
      $display("FAIL stall_lowest: valid=%b dest=%0d required 1 3", rs_alu_sim_valid, rs_alu_sim_dest_pra_idx);
    end
    step();
    checks++;
    if (rs_alu_sim_valid !== 1'b1 || rs_alu_sim_dest_pra_idx !== 6'd2) begin
      errors++;
      $display("FAIL stall_next: valid=%b dest=%0d required 1 2", rs_alu_sim_valid, rs_alu_sim_dest_pra_idx);
    end
    step();
    checks++;
    if (rs_alu_sim_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty: valid=%b required 0", rs_alu_sim_valid);
    end
  endtask

  // Fill entries 0-2 plus the issue slot, then clear by flush or async reset.
  task automatic test_clear(input bit use_reset);
    alu_sim_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_dispatch(k, 1, k + 1, 1, 60 + k, 0, 0);
      step();
    end
    idle();
    if (use_reset) begin
      #3 reset_n = 1'b0;
      #1;
      checks++;
      if (rs_full !== 1'b0 || rs_alu_sim_valid !== 1'b0 || rs_alu_sim_dest_pra_idx !== '0 ||
          rs_alu_sim_pra_idx0 !== '0 || rs_alu_sim_func !== '0 || rs_alu_sim_rob_idx !== '0) begin
        errors++;
        $display("FAIL areset_now: full=%b valid=%b dest=%0d required 0 0 0",
                 rs_full, rs_alu_sim_valid, rs_alu_sim_dest_pra_idx);
      end
      #1 reset_n = 1'b1;
      step();
    end else begin
      flush = 1'b1;
      id_valid = 1'b1;
      alu_sim_ready = 1'b1;
      cdb_valid = 1'b1;
      step();
      idle();
    end
    alu_sim_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rs_full !== 1'b0 || rs_alu_sim_valid !== 1'b0) begin
        errors++;
        $display("FAIL clear%0d_empty%0d: full=%b valid=%b required 0 0", use_reset, k, rs_full, rs_alu_sim_valid);
      end
      step();
    end
    alu_sim_ready = 1'b0;
    drive_dispatch(50, 0, 1, 1, 70, 0, 0);
    step();
    drive_dispatch(50, 0, 1, 1, 71, 0, 0);
    step();
    idle();
    cdb_valid = 1'b1;
    cdb_pra_idx = 6'd50;
    step();
    cdb_valid = 1'b0;
    step();
    checks++;
    if (rs_alu_sim_valid !== 1'b1 || rs_alu_sim_dest_pra_idx !== 6'd70) begin
      errors++;
      $display("FAIL clear%0d_entry0: valid=%b dest=%0d required 1 70", use_reset, rs_alu_sim_valid, rs_alu_sim_dest_pra_idx);
    end
    alu_sim_ready = 1'b1;
    step();
    checks++;
    if (rs_alu_sim_valid !== 1'b1 || rs_alu_sim_dest_pra_idx !== 6'd71) begin
      errors++;
      $display("FAIL clear%0d_entry1: valid=%b dest=%0d required 1 71", use_reset, rs_alu_sim_valid, rs_alu_sim_dest_pra_idx);
    end
    do_flush();
  endtask

  task automatic test_random();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      id_valid        = ($urandom_range(0, 1) == 1);
      id_pra_idx0     = PRA_W'($urandom_range(0, 7));
      id_pra_idx1     = PRA_W'($urandom_range(0, 7));
      id_pra_rdy0     = ($urandom_range(0, 2) == 0);
      id_pra_rdy1     = ($urandom_range(0, 2) == 0);
      id_dest_pra_idx = PRA_W'($urandom);
      id_alu_func     = FUNC_W'($urandom);
      id_rob_idx      = ROB_W'($urandom);
      cdb_valid       = ($urandom_range(0, 9) < 4);
      cdb_pra_idx     = PRA_W'($urandom_range(0, 7));
      alu_sim_ready   = ($urandom_range(0, 9) < 6);
      flush           = ($urandom_range(0, 39) == 0);
      model_edge();
      step();
      checks++;
      if (rs_alu_sim_valid !== m_slot.v || rs_full !== (m_ent[0].v & m_ent[1].v & m_ent[2].v & m_ent[3].v)) begin
        errors++;
        $display("FAIL rand%0d_flags: valid=%b full=%b required %b %b", c, rs_alu_sim_valid, rs_full,
                 m_slot.v, m_ent[0].v & m_ent[1].v & m_ent[2].v & m_ent[3].v);
      end
      if (m_slot.v) begin
        checks++;
        if (rs_alu_sim_pra_idx0 !== PRA_W'(m_slot.t0) || rs_alu_sim_pra_idx1 !== PRA_W'(m_slot.t1) ||
            rs_alu_sim_dest_pra_idx !== PRA_W'(m_slot.dest) || rs_alu_sim_func !== FUNC_W'(m_slot.func) ||
            rs_alu_sim_rob_idx !== ROB_W'(m_slot.rob)) begin
          errors++;
          $display("FAIL rand%0d_data: idx0=%0d idx1=%0d dest=%0d func=%0d rob=%0d required %0d %0d %0d %0d %0d",
                   c, rs_alu_sim_pra_idx0, rs_alu_sim_pra_idx1, rs_alu_sim_dest_pra_idx, rs_alu_sim_func,
                   rs_alu_sim_rob_idx, m_slot.t0, m_slot.t1, m_slot.dest, m_slot.func, m_slot.rob);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_full();
    test_dispatch_bypass();
    test_back_to_back();
    test_clear(1'b0);
    test_clear(1'b1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rs_alu_sim.md
RS_ALU_SIM -- requirements
Module: rs_alu_sim

Interface
REQ-001 SHALL have parameter RS_SIZE, default 4, meaning number of reservation-station entries.
REQ-002 SHALL have parameter PRA_W, default 6, meaning physical-register index width.
REQ-003 SHALL have parameter FUNC_W, default 5, meaning ALU function-code width.
REQ-004 SHALL have parameter ROB_W, default 5, meaning ROB index width.
REQ-005 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous squash of all contents.
REQ-008 SHALL have port id_valid  input  1  dispatch request.
REQ-009 SHALL have ports id_pra_idx0, id_pra_idx1  input  PRA_W each  source physical-register tags.
REQ-010 SHALL have ports id_pra_rdy0, id_pra_rdy1  input  1 each  source value already in PRF.
REQ-011 SHALL have ports id_dest_pra_idx  input  PRA_W; id_alu_func  input  FUNC_W; id_rob_idx  input  ROB_W.
REQ-012 SHALL have ports cdb_valid  input  1 and cdb_pra_idx  input  PRA_W  completion broadcast tag.
REQ-013 SHALL have port alu_sim_ready  input  1  downstream accepts issued op.
REQ-014 SHALL have port rs_full  output  1  all entries occupied; dispatch stall.
REQ-015 SHALL have port rs_alu_sim_valid  output  1  issue slot holds an op.
REQ-016 SHALL have ports rs_alu_sim_pra_idx0, rs_alu_sim_pra_idx1  output  PRA_W each  PRF read indices.
REQ-017 SHALL have ports rs_alu_sim_dest_pra_idx  output  PRA_W; rs_alu_sim_func  output  FUNC_W; rs_alu_sim_rob_idx  output  ROB_W.

Function
REQ-018 Each entry SHALL hold: valid, tag0, rdy0, tag1, rdy1, dest, func, rob.
REQ-019 rs_full SHALL be 1 exactly when all RS_SIZE entry valid bits are 1 (from registered state only).
REQ-020 Dispatch SHALL occur when id_valid=1, rs_full=0, flush=0; writes lowest-indexed invalid entry at the clock edge.
REQ-021 id_valid=1 while rs_full=1 SHALL be ignored; no state change.
REQ-022 On dispatch, rdyN SHALL be stored as id_pra_rdyN OR (cdb_valid AND cdb_pra_idx==id_pra_idxN).
REQ-023 Wakeup: every valid entry with cdb_valid=1 and tagN==cdb_pra_idx SHALL set rdyN=1 at the edge; already-set bits stay 1.
REQ-024 An entry SHALL be eligible when valid, rdy0=1, rdy1=1, using registered bits only (no same-cycle CDB bypass into select).
REQ-025 Select SHALL pick the lowest-indexed eligible entry.
REQ-026 Issue slot SHALL load when (rs_alu_sim_valid=0 OR alu_sim_ready=1) and an eligible entry exists; selected entry's valid clears at the same edge.
REQ-027 When issue slot loads nothing but alu_sim_ready=1, rs_alu_sim_valid SHALL go 0 at the edge.
REQ-028 While rs_alu_sim_valid=1 and alu_sim_ready=0, all rs_alu_sim_* outputs SHALL hold stable.
REQ-029 Latency: op dispatched at edge E with both operands ready SHALL appear with rs_alu_sim_valid=1 after edge E+1 (issue slot empty, no older eligible entry).
REQ-030 CDB wakeup at edge E making an entry eligible SHALL allow issue at edge E+1 earliest.
REQ-031 Simultaneous dispatch and issue SHALL both take effect; dispatch uses an entry invalid before the edge (not the one being freed).
REQ-032 flush=1 SHALL clear all entry valid bits and rs_alu_sim_valid at the edge; dispatch, wakeup, and issue in that cycle SHALL be discarded.

Reset
REQ-033 reset_n=0 SHALL immediately clear all entry valid and rdy bits and rs_alu_sim_valid, independent of clock.
REQ-034 During reset, rs_full=0 and all rs_alu_sim_* data outputs SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL discard all entries and the issue slot; first dispatch after release goes to entry 0.

Verification
REQ-036 Dispatch tag0=3 rdy0=1, tag1=5 rdy1=1, dest=9, alu_sim_ready=1 -> rs_alu_sim_valid=1, pra_idx0=3, pra_idx1=5, dest=9 one edge after dispatch edge.
REQ-037 Dispatch tag1=7 rdy1=0; hold 3 cycles; cdb_valid=1 tag 7 -> no issue before wakeup, issue the edge after wakeup edge.
REQ-038 Four dispatches with rdy=0, alu_sim_ready=0 -> rs_full=1; fifth id_valid ignored; one wakeup+issue and accept -> rs_full=0.
REQ-039 Dispatch tag0=12 rdy0=0 with cdb_valid=1 tag 12 same cycle -> entry stored ready, issues next edge.
REQ-040 Issue slot valid, alu_sim_ready=0 for 4 cycles -> outputs stable; second eligible entry held until accept, then issues lowest index.
REQ-041 Entries 0-2 valid, issue slot valid; assert flush (and separately reset_n=0 asynchronously) -> rs_full=0, rs_alu_sim_valid=0, next dispatch into entry 0.
